// File: rtl/simon_pkt_ingress_pkg.sv
// Shared types for the SIMON packet ingress path: packet geometry and out-FSM states.
package SIMON_definitions;
    localparam int PKT_BYTES = 34;

    typedef logic [PKT_BYTES-1:0][7:0] pkt_t;

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_DONE} ingress_state_t;
endpackage

// File: rtl/simon_pkt_ingress_assembler.sv
// Byte-to-packet assembler: byte index with rx_sof resync, feeding a two-slot ping-pong buffer.
module simon_pkt_assembler
    import SIMON_definitions::*;
#(
    parameter int PKT_BYTES = SIMON_definitions::PKT_BYTES
) (
    input  logic                       clk,
    input  logic                       nR,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_sof,
    output logic                       rx_ready,
    input  logic                       freeSlot,
    output logic [1:0]                 count,
    output logic [PKT_BYTES-1:0][7:0]  rdPkt,
    output logic                       dropPulse
);
    localparam int IDX_W = $clog2(PKT_BYTES);

    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          wrIdx;
    logic                      wrPtr;
    logic                      rdPtr;
    logic [PKT_BYTES-1:0][7:0] slot [2];
    logic                      accept;
    logic                      commit;
    logic [1:0]                countNext;

    // A flagged start-of-frame always lands at byte 0, whatever was in flight.
    assign accept    = rx_valid && rx_ready;
    assign wrIdx     = rx_sof ? '0 : idx;
    assign commit    = accept && (wrIdx == IDX_W'(PKT_BYTES - 1));
    assign dropPulse = accept && rx_sof && (idx != '0);
    assign rdPkt     = slot[rdPtr];

    always_comb begin
        countNext = count;
        if (commit && !freeSlot)
            countNext = count + 2'd1;
        else if (!commit && freeSlot)
            countNext = count - 2'd1;
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            idx      <= '0;
            wrPtr    <= 1'b0;
            rdPtr    <= 1'b0;
            count    <= 2'd0;
            rx_ready <= 1'b0;
        end else begin
            count    <= countNext;
            rx_ready <= (countNext < 2'd2);
            if (freeSlot)
                rdPtr <= ~rdPtr;
            if (accept) begin
                if (commit) begin
                    idx   <= '0;
                    wrPtr <= ~wrPtr;
                end else begin
                    idx <= wrIdx + IDX_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; a slot is only read once count says it is full.
    always_ff @(posedge clk) begin
        if (accept)
            slot[wrPtr][wrIdx] <= rx_data;
    end
endmodule

// File: rtl/simon_pkt_ingress.sv
// Packet ingress for the SIMON core: assembles bytes, then offers packets via newPKT/loadPKT/donePKT.
module simon_pkt_ingress
    import SIMON_definitions::*;
#(
    parameter int PKT_BYTES = SIMON_definitions::PKT_BYTES,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       nR,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    input  logic                       rx_sof,
    output logic                       rx_ready,
    input  logic                       in_loadPKT,
    input  logic                       in_donePKT,
    output logic                       in_newPKT,
    output logic [PKT_BYTES-1:0][7:0]  in,
    output logic [CNT_W-1:0]           pkt_count,
    output logic [CNT_W-1:0]           drop_count
);
    ingress_state_t            state, stateNext;
    logic [1:0]                count;
    logic [PKT_BYTES-1:0][7:0] rdPkt;
    logic                      dropPulse;
    logic                      freeSlot;
    logic                      loadIn;
    logic                      newPktNext;

    simon_pkt_assembler #(.PKT_BYTES(PKT_BYTES)) uAsm (
        .clk       (clk),
        .nR        (nR),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .rx_ready  (rx_ready),
        .freeSlot  (freeSlot),
        .count     (count),
        .rdPkt     (rdPkt),
        .dropPulse (dropPulse)
    );

    always_comb begin
        stateNext  = state;
        loadIn     = 1'b0;
        newPktNext = in_newPKT;
        freeSlot   = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    loadIn     = 1'b1;
                    newPktNext = 1'b1;
                    stateNext  = OFFER;
                end
            end
            OFFER: begin
                if (in_loadPKT) begin
                    newPktNext = 1'b0;
                    freeSlot   = 1'b1;
                    stateNext  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Chain straight into the next offer when one is already buffered.
                if (in_donePKT) begin
                    if (count != 2'd0) begin
                        loadIn     = 1'b1;
                        newPktNext = 1'b1;
                        stateNext  = OFFER;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                newPktNext = 1'b0;
                stateNext  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state      <= IDLE;
            in_newPKT  <= 1'b0;
            in         <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state     <= stateNext;
            in_newPKT <= newPktNext;
            if (loadIn)
                in <= rdPkt;
            if (freeSlot)
                pkt_count <= pkt_count + CNT_W'(1);
            if (dropPulse)
                drop_count <= drop_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_simon_pkt_ingress.sv
// Directed bench for simon_pkt_ingress: fill, back-pressure, resync, chaining, reset and same-edge cases.
module tb_simon_pkt_ingress;
    import SIMON_definitions::*;

    localparam int CNT_W = 16;
    localparam int W     = PKT_BYTES * 8;

    logic             clk = 1'b0;
    logic             nR  = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_sof = 1'b0;
    logic             rx_ready;
    logic             in_loadPKT = 1'b0;
    logic             in_donePKT = 1'b0;
    logic             in_newPKT;
    pkt_t             in;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] drop_count;

    int errors = 0;
    int checks = 0;
    int accCnt = 0;
    pkt_t expPkt;

    always #5 clk = ~clk;

    simon_pkt_ingress #(.PKT_BYTES(PKT_BYTES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .nR         (nR),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_ready   (rx_ready),
        .in_loadPKT (in_loadPKT),
        .in_donePKT (in_donePKT),
        .in_newPKT  (in_newPKT),
        .in         (in),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pkt_t mkPkt(input logic [7:0] base);
        pkt_t p;
        for (int i = 0; i < PKT_BYTES; i++)
            p[i] = base + 8'(i);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic sof);
        bit acc;
        int n;
        n = 0;
        rx_data  = d;
        rx_sof   = sof;
        rx_valid = 1'b1;
        do begin
            acc = rx_ready;
            tick();
            n++;
        end while (!acc && n < 500);
        if (!acc)
            check("rx_timeout", 0, 1);
        else
            accCnt++;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
    endtask

    task automatic sendPkt(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            sendByte(base + 8'(i), 1'b0);
    endtask

    task automatic doLoad();
        in_loadPKT = 1'b1;
        tick();
        in_loadPKT = 1'b0;
    endtask

    task automatic doDone();
        repeat (9) tick();
        in_donePKT = 1'b1;
        tick();
        in_donePKT = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset
        #2 nR = 1'b0;
        tick();
        tick();
        check("rst_ready", rx_ready, 0);
        check("rst_newpkt", in_newPKT, 0);
        check("rst_in", in, 0);
        check("rst_pktcnt", pkt_count, 0);
        check("rst_dropcnt", drop_count, 0);
        nR = 1'b1;
        check("rst_ready_rel", rx_ready, 0);
        tick();
        check("rst_ready_up", rx_ready, 1);

        // 1: single packet, offer latency and byte order
        sendPkt(8'h00, PKT_BYTES);
        check("t1_lat_early", in_newPKT, 0);
        tick();
        check("t1_lat", in_newPKT, 1);
        check("t1_in0", in[0], 8'h00);
        check("t1_in33", in[PKT_BYTES-1], 8'h21);
        check("t1_pkt", in, mkPkt(8'h00));
        tick();
        doLoad();
        check("t1_load_newpkt", in_newPKT, 0);
        check("t1_pktcnt", pkt_count, 1);
        doDone();
        check("t1_idle", in_newPKT, 0);

        // 2 + 4: three packets against a stalled core, then chained offers
        sendPkt(8'h40, PKT_BYTES);
        sendPkt(8'h80, PKT_BYTES);
        check("t2_full", rx_ready, 0);
        check("t2_offerA", in_newPKT, 1);
        check("t2_pktA", in, mkPkt(8'h40));
        accCnt = 0;
        fork
            sendPkt(8'hC0, PKT_BYTES);
            begin
                repeat (5) tick();
                check("t2_stall", accCnt, 0);
                check("t2_held", in, mkPkt(8'h40));
                doLoad();
            end
        join
        check("t2_pktcnt", pkt_count, 2);
        doDone();
        check("t4_nobubble", in_newPKT, 1);
        check("t2_pktB", in, mkPkt(8'h80));
        doLoad();
        doDone();
        check("t2_offerC", in_newPKT, 1);
        check("t2_pktC", in, mkPkt(8'hC0));
        doLoad();
        doDone();
        check("t2_idle", in_newPKT, 0);
        check("t2_pktcnt_end", pkt_count, 4);

        // 3: rx_sof resync discards a 10-byte partial
        sendPkt(8'h10, 10);
        sendByte(8'hA5, 1'b1);
        expPkt[0] = 8'hA5;
        for (int i = 1; i < PKT_BYTES; i++) begin
            expPkt[i] = 8'h50 + 8'(i);
            sendByte(8'h50 + 8'(i), 1'b0);
        end
        check("t3_drop", drop_count, 1);
        tick();
        check("t3_offer", in_newPKT, 1);
        check("t3_pkt", in, expPkt);
        doLoad();
        doDone();
        check("t3_pktcnt", pkt_count, 5);

        // 5: reset while offering
        sendPkt(8'h20, PKT_BYTES);
        tick();
        check("t5_offer", in_newPKT, 1);
        #3 nR = 1'b0;
        #1;
        check("t5_async_newpkt", in_newPKT, 0);
        check("t5_async_in", in, 0);
        check("t5_async_pktcnt", pkt_count, 0);
        check("t5_async_drop", drop_count, 0);
        @(posedge clk);
        #1 nR = 1'b1;
        repeat (5) tick();
        check("t5_no_stale", in_newPKT, 0);
        sendPkt(8'h60, PKT_BYTES - 1);
        repeat (3) tick();
        check("t5_partial", in_newPKT, 0);
        sendByte(8'h60 + 8'(PKT_BYTES - 1), 1'b0);
        tick();
        check("t5_offer_new", in_newPKT, 1);
        check("t5_pkt", in, mkPkt(8'h60));
        doLoad();
        doDone();

        // 6: final-byte commit on the same edge as loadPKT
        sendPkt(8'h30, PKT_BYTES);
        tick();
        check("t6_offerP", in_newPKT, 1);
        sendPkt(8'h70, PKT_BYTES - 1);
        check("t6_ready_pre", rx_ready, 1);
        rx_data    = 8'h70 + 8'(PKT_BYTES - 1);
        rx_valid   = 1'b1;
        in_loadPKT = 1'b1;
        tick();
        rx_valid   = 1'b0;
        in_loadPKT = 1'b0;
        check("t6_newpkt", in_newPKT, 0);
        check("t6_ready", rx_ready, 1);
        check("t6_pktcnt", pkt_count, 2);
        doDone();
        check("t6_offerQ", in_newPKT, 1);
        check("t6_pktQ", in, mkPkt(8'h70));
        doLoad();
        doDone();
        check("t6_idle", in_newPKT, 0);
        check("t6_pktcnt_end", pkt_count, 3);
        check("t6_drop", drop_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
